uart_tx_serializer: RTL and testbench

//  UART transmit serializer clocked by the divided clock produced by the clock-divider stage.
//  - One i_clk cycle = one bit time.
//  - Accepts a parallel word with a valid/busy handshake.
//  - Emits a frame: start bit, data LSB-first, optional parity, then stop bit(s).
//  - Sits directly downstream of the clock divider, between the system control logic and the TX pin.

---
 rtl/uart_tx_serializer.sv | 117 +++++++++++
 tb/tb_uart_tx_serializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one i_clk cycle per bit, frame = start, data LSB-first,
// optional parity, stop bit(s). All outputs are registered.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The bit counter is shared: it indexes data bits, then counts stop bits.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            IDLE: begin
                if (i_data_valid) begin
                    state_d   = START;
                    shift_d   = i_p_data;
                    par_en_d  = i_par_en;
                    par_bit_d = (^i_p_data) ^ i_par_typ;
                end
            end
            START: state_d = DATA;
            DATA: begin
                if (cnt_q == LAST_DATA) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                if (cnt_q == LAST_STOP) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line lands on the same edge.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign o_tx_out = tx_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (1 and 2 stop bits) share stimulus lines;
// expected line bits are pushed per frame and popped by a negedge monitor.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_a, valid_b;
    logic [7:0] p_data;
    logic       par_en, par_typ;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    logic       tx_w[2];
    logic       busy_w[2];
    logic       done_w[2];

    // Entry: bit 0 = expected line, bit 1 = expected done (busy expected as its inverse).
    logic [1:0] q[2][$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data_valid(valid_a), .i_p_data(p_data),
        .i_par_en(par_en), .i_par_typ(par_typ),
        .o_tx_out(tx_a), .o_busy(busy_a), .o_done(done_a)
    );

    uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data_valid(valid_b), .i_p_data(p_data),
        .i_par_en(par_en), .i_par_typ(par_typ),
        .o_tx_out(tx_b), .o_busy(busy_b), .o_done(done_b)
    );

    assign tx_w[0]   = tx_a;
    assign tx_w[1]   = tx_b;
    assign busy_w[0] = busy_a;
    assign busy_w[1] = busy_b;
    assign done_w[0] = done_a;
    assign done_w[1] = done_b;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [1:0] e;
                if (busy_w[d] || done_w[d]) begin
                    checks++;
                    if (q[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output dut%0d: tx=%b busy=%b done=%b, required idle tx=1 busy=0 done=0",
                                 d, tx_w[d], busy_w[d], done_w[d]);
                    end else begin
                        e = q[d].pop_front();
                        if (tx_w[d] !== e[0] || done_w[d] !== e[1] || busy_w[d] !== ~e[1]) begin
                            errors++;
                            $display("FAIL frame_bit dut%0d: tx=%b busy=%b done=%b, required tx=%b busy=%b done=%b",
                                     d, tx_w[d], busy_w[d], done_w[d], e[0], ~e[1], e[1]);
                        end
                    end
                end else begin
                    checks++;
                    if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_line dut%0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                                 d, tx_w[d], busy_w[d], done_w[d]);
                    end
                end
            end
        end
    end

    // Expected line written as a string, first character = start bit; a done cycle follows.
    task automatic push_frame(input int d, input string s);
        for (int i = 0; i < s.len(); i++)
            q[d].push_back({1'b0, (s[i] == "1") ? 1'b1 : 1'b0});
        q[d].push_back(2'b11);
        $display("frame queued dut%0d: data=%h par_en=%b par_typ=%b line=%s", d, p_data, par_en, par_typ, s);
    endtask

    // Called just after a posedge; returns just after the accept edge with valid dropped.
    task automatic send(input int d, input logic [7:0] data, input logic pe, input logic pt, input string s);
        p_data  = data;
        par_en  = pe;
        par_typ = pt;
        if (d == 0) valid_a = 1'b1; else valid_b = 1'b1;
        push_frame(d, s);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d entries left, required 0/0", name, q[0].size(), q[1].size());
            q[0].delete();
            q[1].delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        p_data  = 8'h00;
        par_en  = 1'b0;
        par_typ = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 even parity, inputs scrambled mid-frame
        send(0, 8'hA5, 1'b1, 1'b0, "01010010101");
        p_data = 8'h00; par_en = 1'b0; par_typ = 1'b1;
        wait_idle("a5_even");

        send(0, 8'hA5, 1'b1, 1'b1, "01010010111");
        wait_idle("a5_odd");

        send(0, 8'h00, 1'b0, 1'b0, "0000000001");
        wait_idle("zero_nopar");

        // Valid held across two words: second start right after the done cycle
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; valid_a = 1'b1;
        push_frame(0, "0001111001");
        @(posedge clk);
        #1;
        p_data = 8'hC3;
        push_frame(0, "0110000111");
        repeat (11) @(posedge clk);
        #1;
        valid_a = 1'b0;
        wait_idle("back_to_back");

        // Reset while data bit 3 is on the line aborts the frame silently
        send(0, 8'h5A, 1'b0, 1'b0, "0010110101");
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q[0].delete();
        repeat (3) @(posedge clk);
        #1;
        send(0, 8'h96, 1'b1, 1'b1, "00110100111");
        wait_idle("after_abort");

        // Reset and valid together: word must not be taken
        rst = 1'b1; valid_a = 1'b1; p_data = 8'h12;
        @(posedge clk);
        #1;
        rst = 1'b0; valid_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Two stop bits, data toggled during the frame
        send(1, 8'hFF, 1'b1, 1'b0, "011111111011");
        for (int i = 0; i < 6; i++) begin
            p_data = ~p_data;
            par_typ = ~par_typ;
            @(posedge clk);
            #1;
        end
        wait_idle("two_stop");

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
